// File: rtl/t05_data_memory_ctrl.sv
// t05_data_memory_ctrl
//   Data memory controller between the core's load/store stage and the shared
//   memory bus. Stores are posted into a small write buffer and the CPU is
//   released at once. Loads stall the CPU and are issued on the bus only once
//   every buffered store has drained, so a load always sees earlier stores.
//   A bus access that is not acknowledged within TIMEOUT cycles is abandoned
//   and signalled to the CPU with a one-cycle error pulse.
//
// Ports
//   clk, nrst                   clock (rising edge), async active-low reset
//   cpu_read_i / cpu_write_i    load / store request, held while cpu_stall_o
//   cpu_adr_i, cpu_wdata_i,
//   cpu_sel_i                   request address, store data, store byte lanes
//   cpu_rdata_o                 load data, valid in the response cycle and held
//   cpu_stall_o                 CPU must hold its request (combinational)
//   cpu_err_o                   one-cycle pulse when a bus access times out
//   bus_read_o / bus_write_o    bus strobes, never both high
//   bus_adr_o, bus_wdata_o,
//   bus_sel_o                   bus address, write data, byte enables
//   bus_rdata_i, bus_good_i     bus read data, access-complete handshake
//   wbuf_count_o                number of buffered stores
module t05_data_memory_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          cpu_read_i,
    input  logic                          cpu_write_i,
    input  logic [ADDR_W-1:0]             cpu_adr_i,
    input  logic [DATA_W-1:0]             cpu_wdata_i,
    input  logic [DATA_W/8-1:0]           cpu_sel_i,
    output logic [DATA_W-1:0]             cpu_rdata_o,
    output logic                          cpu_stall_o,
    output logic                          cpu_err_o,
    output logic                          bus_read_o,
    output logic                          bus_write_o,
    output logic [ADDR_W-1:0]             bus_adr_o,
    output logic [DATA_W-1:0]             bus_wdata_o,
    output logic [DATA_W/8-1:0]           bus_sel_o,
    input  logic [DATA_W-1:0]             bus_rdata_i,
    input  logic                          bus_good_i,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count_o
);

    localparam int SEL_W  = DATA_W / 8;
    localparam int PTR_W  = $clog2(WBUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TLAST    = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WBUF_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } wbuf_ent_t;

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t                       state;
    wbuf_ent_t [WBUF_DEPTH-1:0]   wbuf_mem;
    wbuf_ent_t                    head;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             wbuf_cnt;
    logic [TCNT_W-1:0]            tcnt;
    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;
    logic                         timeout_hit;

    // Full is taken from the registered count, so a store arriving in the
    // same cycle the bus retires an entry still waits one cycle.
    assign full         = (wbuf_cnt == FULL_CNT);
    assign empty        = (wbuf_cnt == '0);
    assign head         = wbuf_mem[rd_ptr];
    assign wbuf_count_o = wbuf_cnt;

    // A simultaneous load and store is served as a load only.
    assign push = cpu_write_i & ~cpu_read_i & ~full;

    // Last cycle the access may wait; the strobe drops at this edge.
    assign timeout_hit = (TIMEOUT > 0) && (tcnt == TLAST) && !bus_good_i;

    // Timed-out stores are popped too: the store is lost, the buffer moves on.
    assign pop = (state == WR) && (bus_good_i || timeout_hit);

    assign cpu_stall_o = (cpu_read_i & (state != RESP)) |
                         (cpu_write_i & ~cpu_read_i & full);

    // Buffer storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (push) wbuf_mem[wr_ptr] <= {cpu_adr_i, cpu_wdata_i, cpu_sel_i};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wbuf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   wbuf_cnt <= wbuf_cnt + CNT_W'(1);
                2'b01:   wbuf_cnt <= wbuf_cnt - CNT_W'(1);
                default: wbuf_cnt <= wbuf_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            tcnt        <= '0;
            cpu_rdata_o <= '0;
            cpu_err_o   <= 1'b0;
            bus_read_o  <= 1'b0;
            bus_write_o <= 1'b0;
            bus_adr_o   <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
        end else begin
            cpu_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Draining stores first keeps loads ordered behind them.
                    if (!empty) begin
                        state       <= WR;
                        tcnt        <= '0;
                        bus_write_o <= 1'b1;
                        bus_adr_o   <= head.adr;
                        bus_wdata_o <= head.wdata;
                        bus_sel_o   <= head.sel;
                    end else if (cpu_read_i) begin
                        state      <= RD;
                        tcnt       <= '0;
                        bus_read_o <= 1'b1;
                        bus_adr_o  <= cpu_adr_i;
                        bus_sel_o  <= '1;
                    end
                end
                WR: begin
                    if (bus_good_i) begin
                        state       <= IDLE;
                        bus_write_o <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        bus_write_o <= 1'b0;
                        cpu_err_o   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                RD: begin
                    if (bus_good_i) begin
                        state       <= RESP;
                        bus_read_o  <= 1'b0;
                        cpu_rdata_o <= bus_rdata_i;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        bus_read_o  <= 1'b0;
                        cpu_rdata_o <= '0;
                        cpu_err_o   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
